// File: rtl/counter_mode_ctrl.sv
// Button front end for the lab-7 up/down/step counter: sync, debounce, press detect, mode toggle.
// Optional ping-pong auto-reverse is compiled in when AUTO_REVERSE_EN is defined.
module counter_mode_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int DB_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_step,
    input  logic       btn_dir,
    input  logic [3:0] cnt,
    output logic       step,
    output logic       down,
    output logic       mode_chg
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Index 0 is the step button, index 1 the direction button.
    logic [1:0]                  btnRaw;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0]                  syncLevel;
    logic [1:0]                  dbLevel_q, dbLevel_d;
    logic [1:0]                  dbPrev_q;
    logic [1:0][DB_W-1:0]        dbCount_q, dbCount_d;
    logic [1:0]                  press;
    logic                        step_q, step_d;
    logic                        down_q, down_d;
    logic                        modeChg_q, modeChg_d;

    assign btnRaw = {btn_dir, btn_step};

    always_comb begin
        dbLevel_d = dbLevel_q;
        dbCount_d = dbCount_q;
        for (int i = 0; i < 2; i++) begin
            syncLevel[i] = sync_q[i][SYNC_STAGES-1];
            if (syncLevel[i] == dbLevel_q[i]) begin
                dbCount_d[i] = '0;
            end else if (dbCount_q[i] == DB_LAST) begin
                dbLevel_d[i] = syncLevel[i];
                dbCount_d[i] = '0;
            end else begin
                dbCount_d[i] = dbCount_q[i] + 1'b1;
            end
        end
    end

    assign press = dbLevel_q & ~dbPrev_q;

`ifdef AUTO_REVERSE_EN
    logic [4:0] inc5;
    logic [4:0] cnt5;
    logic       revUp;
    logic       revDown;

    assign inc5    = step_q ? 5'd2 : 5'd1;
    assign cnt5    = {1'b0, cnt};
    assign revUp   = !down_q && ((cnt5 + inc5) <= 5'd15) && ((cnt5 + (inc5 << 1)) > 5'd15);
    assign revDown = down_q && (cnt5 >= inc5) && (cnt5 < (inc5 << 1));
`else
    logic unusedCnt;
    assign unusedCnt = ^cnt;
`endif

    // An auto-reverse overrides any direction press landing in the same cycle.
    always_comb begin
        step_d = step_q ^ press[0];
        down_d = down_q ^ press[1];
`ifdef AUTO_REVERSE_EN
        if (revUp) begin
            down_d = 1'b1;
        end else if (revDown) begin
            down_d = 1'b0;
        end
`endif
        modeChg_d = (step_d != step_q) || (down_d != down_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            dbLevel_q <= '0;
            dbPrev_q  <= '0;
            dbCount_q <= '0;
            step_q    <= 1'b0;
            down_q    <= 1'b0;
            modeChg_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btnRaw[i]};
            end
            dbLevel_q <= dbLevel_d;
            dbPrev_q  <= dbLevel_q;
            dbCount_q <= dbCount_d;
            step_q    <= step_d;
            down_q    <= down_d;
            modeChg_q <= modeChg_d;
        end
    end

    assign step     = step_q;
    assign down     = down_q;
    assign mode_chg = modeChg_q;

endmodule

// File: tb/tb_counter_mode_ctrl.sv
// Self-checking bench for counter_mode_ctrl: vector table with a scoreboard queue plus
// hand-written latency, reset and auto-reverse sequences.
module tb_counter_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnStep = 1'b0;
    logic       btnDir = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic       step;
    logic       down;
    logic       modeChg;

    int testsRun = 0;
    int testsFailed = 0;
    int pulseTotal = 0;

    typedef struct {
        string name;
        logic  bs;
        logic  bd;
        int    hold;
        logic  expStep;
        logic  expDown;
        int    expPulses;
    } vec_t;

    typedef struct {
        string name;
        logic  expStep;
        logic  expDown;
        int    expPulses;
        int    pulseStart;
    } exp_t;

    vec_t vectors[8];
    exp_t sbQ[$];

    counter_mode_ctrl #(
        .SYNC_STAGES(2),
        .DB_CYCLES(16),
        .DB_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_step(btnStep),
        .btn_dir(btnDir),
        .cnt(cnt),
        .step(step),
        .down(down),
        .mode_chg(modeChg)
    );

    always #5 clk = ~clk;

    // Count every cycle mode_chg is seen high, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && modeChg) pulseTotal++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            e = sbQ.pop_front();
            checkVal({e.name, " step"}, {31'd0, step}, {31'd0, e.expStep});
            checkVal({e.name, " down"}, {31'd0, down}, {31'd0, e.expDown});
            checkVal({e.name, " pulses"}, pulseTotal - e.pulseStart, e.expPulses);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.name       = v.name;
        e.expStep    = v.expStep;
        e.expDown    = v.expDown;
        e.expPulses  = v.expPulses;
        e.pulseStart = pulseTotal;
        sbQ.push_back(e);
        btnStep = v.bs;
        btnDir  = v.bd;
        tick(v.hold);
        btnStep = 1'b0;
        btnDir  = 1'b0;
        tick(25);
        checkOutput();
    endtask

    initial begin
        int start;
        logic arDown;
        vec_t rep;

`ifdef AUTO_REVERSE_EN
        arDown = 1'b1;
`else
        arDown = 1'b0;
`endif

        vectors[0] = '{"step press",       1'b1, 1'b0, 30, 1'b1, 1'b0, 1};
        vectors[1] = '{"dir press",        1'b0, 1'b1, 30, 1'b1, 1'b1, 1};
        vectors[2] = '{"step glitch 10",   1'b1, 1'b0, 10, 1'b1, 1'b1, 0};
        vectors[3] = '{"both press",       1'b1, 1'b1, 30, 1'b0, 1'b0, 1};
        vectors[4] = '{"dir glitch 15",    1'b0, 1'b1, 15, 1'b0, 1'b0, 0};
        vectors[5] = '{"dir hold 16",      1'b0, 1'b1, 16, 1'b0, 1'b1, 1};
        vectors[6] = '{"step hold 16",     1'b1, 1'b0, 16, 1'b1, 1'b1, 1};
        vectors[7] = '{"step glitch 15",   1'b1, 1'b0, 15, 1'b1, 1'b1, 0};

        #1;
        checkVal("reset step", {31'd0, step}, 0);
        checkVal("reset down", {31'd0, down}, 0);
        checkVal("reset mode_chg", {31'd0, modeChg}, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i]);
        end

        // Asynchronous reset with both mode bits set, checked before the next edge.
        #2;
        rst = 1'b1;
        #1;
        checkVal("async rst step", {31'd0, step}, 0);
        checkVal("async rst down", {31'd0, down}, 0);
        checkVal("async rst mode_chg", {31'd0, modeChg}, 0);
        tick(1);

        // Press latency from reset release and hold behaviour.
        rst    = 1'b0;
        btnDir = 1'b1;
        start  = pulseTotal;
        tick(18);
        checkVal("latency edge 18 down", {31'd0, down}, 0);
        tick(1);
        checkVal("latency edge 19 down", {31'd0, down}, 1);
        tick(20);
        checkVal("held dir down", {31'd0, down}, 1);
        checkVal("held dir pulses", pulseTotal - start, 1);
        btnDir = 1'b0;
        tick(25);
        rep = '{"dir repress", 1'b0, 1'b1, 30, 1'b0, 1'b0, 1};
        applyStimulus(rep);

        // Reset in the middle of a debounce discards the partial count.
        btnDir = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(18);
        checkVal("rst mid-debounce edge 18 down", {31'd0, down}, 0);
        tick(1);
        checkVal("rst mid-debounce edge 19 down", {31'd0, down}, 1);
        btnDir = 1'b0;
        tick(25);

        // Ping-pong reversal at the top and bottom with step = 0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        cnt = 4'd13;
        tick(1);
        checkVal("cnt 13 down", {31'd0, down}, 0);
        cnt = 4'd14;
        tick(1);
        checkVal("cnt 14 down", {31'd0, down}, {31'd0, arDown});
        checkVal("cnt 14 mode_chg", {31'd0, modeChg}, {31'd0, arDown});
        cnt = 4'd15;
        tick(1);
        checkVal("cnt 15 down", {31'd0, down}, {31'd0, arDown});
        cnt = 4'd1;
        tick(1);
        checkVal("cnt 1 down", {31'd0, down}, 0);
        cnt = 4'd0;
        tick(2);

        // Step = 1 top-boundary reversal.
        rep = '{"step for ar", 1'b1, 1'b0, 30, 1'b1, 1'b0, 1};
        applyStimulus(rep);
        cnt = 4'd12;
        tick(1);
        checkVal("step2 cnt 12 down", {31'd0, down}, {31'd0, arDown});
        cnt = 4'd0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
